// File: rtl/tvp7002_mode_ctrl_if.sv
// Frontend measurement, CPU config and mode-status bundle for tvp7002_mode_ctrl.
// The slave modport is the controller; master is the frontend/CPU side driving it.
interface tvp7002_mode_ctrl_if;
  logic        sync_active_i;
  logic [10:0] vtotal_i;
  logic [19:0] pcnt_frame_i;
  logic        interlace_i;
  logic        frame_tick_i;
  logic        cfg_wr_i;
  logic [1:0]  cfg_sel_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_commit_i;
  logic        irq_ack_i;
  logic        cfg_pending_o;
  logic [31:0] hv_in_config_o;
  logic [31:0] hv_in_config2_o;
  logic [31:0] hv_in_config3_o;
  logic [1:0]  mode_state_o;
  logic [10:0] mode_vtotal_o;
  logic [19:0] mode_pcnt_frame_o;
  logic        mode_interlace_o;
  logic        irq_o;

  modport slave (
    input  sync_active_i, vtotal_i, pcnt_frame_i, interlace_i, frame_tick_i,
           cfg_wr_i, cfg_sel_i, cfg_wdata_i, cfg_commit_i, irq_ack_i,
    output cfg_pending_o, hv_in_config_o, hv_in_config2_o, hv_in_config3_o,
           mode_state_o, mode_vtotal_o, mode_pcnt_frame_o, mode_interlace_o, irq_o
  );

  modport master (
    output sync_active_i, vtotal_i, pcnt_frame_i, interlace_i, frame_tick_i,
           cfg_wr_i, cfg_sel_i, cfg_wdata_i, cfg_commit_i, irq_ack_i,
    input  cfg_pending_o, hv_in_config_o, hv_in_config2_o, hv_in_config3_o,
           mode_state_o, mode_vtotal_o, mode_pcnt_frame_o, mode_interlace_o, irq_o
  );
endinterface

// File: rtl/tvp7002_mode_ctrl.sv
// TVP7002 mode detect / lock sequencer with frame-aligned atomic hv_in_config update.
// Define MODE_CTRL_IRQ_EN to build the sticky mode-event interrupt; otherwise irq_o is tied 0.
module tvp7002_mode_ctrl #(
  parameter int STABLE_FRAMES = 4,
  parameter int VTOTAL_TOL    = 1,
  parameter int PCNT_TOL      = 64
) (
  input logic               CLK_MEAS_i,
  input logic               reset_n,
  tvp7002_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {NOSYNC = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [10:0]       ref_vt_q, ref_vt_d;
  logic [19:0]       ref_pc_q, ref_pc_d;
  logic              ref_il_q, ref_il_d;
  logic              ref_valid_q, ref_valid_d;
  logic [3:0]        ctr_q, ctr_d, ctr_inc;
  logic [10:0]       mvt_q, mvt_d;
  logic [19:0]       mpc_q, mpc_d;
  logic              mil_q, mil_d;
  logic [2:0][31:0]  shadow_q, shadow_d;
  logic [2:0][31:0]  cfg_q, cfg_d;
  logic              pending_q, pending_d;
  logic              irq_evt, apply, load_ref, match;
  logic [11:0]       vt_diff;
  logic [20:0]       pc_diff;

  // One bit wider than the operands so the absolute difference never wraps.
  always_comb begin
    vt_diff = ({1'b0, bus.vtotal_i} >= {1'b0, ref_vt_q}) ?
              {1'b0, bus.vtotal_i} - {1'b0, ref_vt_q} : {1'b0, ref_vt_q} - {1'b0, bus.vtotal_i};
    pc_diff = ({1'b0, bus.pcnt_frame_i} >= {1'b0, ref_pc_q}) ?
              {1'b0, bus.pcnt_frame_i} - {1'b0, ref_pc_q} : {1'b0, ref_pc_q} - {1'b0, bus.pcnt_frame_i};
    match   = (vt_diff <= 12'(VTOTAL_TOL)) && (pc_diff <= 21'(PCNT_TOL)) &&
              (bus.interlace_i == ref_il_q);
    ctr_inc = ctr_q + 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    ref_valid_d = ref_valid_q;
    ctr_d       = ctr_q;
    mvt_d       = mvt_q;
    mpc_d       = mpc_q;
    mil_d       = mil_q;
    irq_evt     = 1'b0;
    load_ref    = 1'b0;
    if (!bus.sync_active_i) begin
      state_d     = NOSYNC;
      ref_valid_d = 1'b0;
      ctr_d       = 4'd0;
      irq_evt     = (state_q == LOCKED);
    end else begin
      case (state_q)
        NOSYNC: begin
          state_d     = ACQUIRE;
          ref_valid_d = 1'b0;
        end
        ACQUIRE: if (bus.frame_tick_i) begin
          if (!ref_valid_q) begin
            load_ref    = 1'b1;
            ref_valid_d = 1'b1;
            ctr_d       = 4'd0;
          end else if (match) begin
            ctr_d = ctr_inc;
            if (ctr_inc == 4'(STABLE_FRAMES)) begin
              state_d = LOCKED;
              mvt_d   = bus.vtotal_i;
              mpc_d   = bus.pcnt_frame_i;
              mil_d   = bus.interlace_i;
              irq_evt = 1'b1;
            end
          end else begin
            load_ref = 1'b1;
            ctr_d    = 4'd0;
          end
        end
        LOCKED: if (bus.frame_tick_i && !match) begin
          state_d  = ACQUIRE;
          load_ref = 1'b1;
          ctr_d    = 4'd0;
          irq_evt  = 1'b1;
        end
        default: state_d = NOSYNC;
      endcase
    end
    ref_vt_d = load_ref ? bus.vtotal_i     : ref_vt_q;
    ref_pc_d = load_ref ? bus.pcnt_frame_i : ref_pc_q;
    ref_il_d = load_ref ? bus.interlace_i  : ref_il_q;
  end

  // Without sync there is no frame boundary to wait for, so a commit applies at once.
  // Otherwise only the registered pending flag is honoured, so a commit coinciding
  // with a tick waits for the next one.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.cfg_wr_i) begin
      case (bus.cfg_sel_i)
        2'd0:    shadow_d[0] = bus.cfg_wdata_i;
        2'd1:    shadow_d[1] = bus.cfg_wdata_i;
        2'd2:    shadow_d[2] = bus.cfg_wdata_i;
        default: shadow_d = shadow_q;
      endcase
    end
    if (state_q == NOSYNC) begin
      apply     = pending_q | bus.cfg_commit_i;
      pending_d = 1'b0;
    end else begin
      apply     = pending_q & bus.frame_tick_i;
      pending_d = bus.cfg_commit_i | (pending_q & ~bus.frame_tick_i);
    end
    cfg_d = apply ? shadow_q : cfg_q;
  end

  always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= NOSYNC;
      ref_vt_q    <= '0;
      ref_pc_q    <= '0;
      ref_il_q    <= 1'b0;
      ref_valid_q <= 1'b0;
      ctr_q       <= '0;
      mvt_q       <= '0;
      mpc_q       <= '0;
      mil_q       <= 1'b0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_vt_q    <= ref_vt_d;
      ref_pc_q    <= ref_pc_d;
      ref_il_q    <= ref_il_d;
      ref_valid_q <= ref_valid_d;
      ctr_q       <= ctr_d;
      mvt_q       <= mvt_d;
      mpc_q       <= mpc_d;
      mil_q       <= mil_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      pending_q   <= pending_d;
    end
  end

`ifdef MODE_CTRL_IRQ_EN
  logic irq_q;
  // A new event wins over a simultaneous ack.
  always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_evt | (irq_q & ~bus.irq_ack_i);
  end
  assign bus.irq_o = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_evt ^ bus.irq_ack_i;
  assign bus.irq_o  = 1'b0;
`endif

  assign bus.mode_state_o      = state_q;
  assign bus.mode_vtotal_o     = mvt_q;
  assign bus.mode_pcnt_frame_o = mpc_q;
  assign bus.mode_interlace_o  = mil_q;
  assign bus.cfg_pending_o     = pending_q;
  assign bus.hv_in_config_o    = cfg_q[0];
  assign bus.hv_in_config2_o   = cfg_q[1];
  assign bus.hv_in_config3_o   = cfg_q[2];

endmodule

// File: tb/tb_tvp7002_mode_ctrl.sv
// Directed bench for tvp7002_mode_ctrl: table of per-cycle vectors for the lock/tolerance/
// sync-loss flow, then hand sequences for commit timing, races and reset.
module tb_tvp7002_mode_ctrl;
`ifdef MODE_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  tvp7002_mode_ctrl_if bus ();

  tvp7002_mode_ctrl #(.STABLE_FRAMES(4), .VTOTAL_TOL(1), .PCNT_TOL(64)) dut (
    .CLK_MEAS_i (gclk),
    .reset_n    (grst_n),
    .bus        (bus.slave)
  );

  typedef struct {
    logic        sync, tick, il, ack;
    logic [10:0] vt;
    logic [19:0] pc;
    logic [1:0]  st;
    logic [10:0] mvt;
    logic        mil, irq;
  } vec_t;

  vec_t tbl[36];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic sync, logic tick, logic [10:0] vt, logic [19:0] pc,
                              logic il, logic ack, logic [1:0] st, logic [10:0] mvt,
                              logic mil, logic irq);
    vec_t v;
    v.sync = sync; v.tick = tick; v.vt = vt; v.pc = pc; v.il = il; v.ack = ack;
    v.st = st; v.mvt = mvt; v.mil = mil; v.irq = irq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sync, input logic tick, input logic [10:0] vt,
                       input logic [19:0] pc, input logic il, input logic ack);
    bus.sync_active_i = sync; bus.frame_tick_i = tick; bus.vtotal_i = vt;
    bus.pcnt_frame_i = pc; bus.interlace_i = il; bus.irq_ack_i = ack;
  endtask

  task automatic step();
    @(posedge gclk); #1;
    bus.frame_tick_i = 1'b0; bus.irq_ack_i = 1'b0;
    bus.cfg_wr_i = 1'b0; bus.cfg_commit_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus.cfg_wr_i = 1'b1; bus.cfg_sel_i = sel; bus.cfg_wdata_i = d;
    step();
  endtask

  task automatic chk_cfg(input string name, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic pend);
    chk({name, ".cfg"},  bus.hv_in_config_o,  c0);
    chk({name, ".cfg2"}, bus.hv_in_config2_o, c1);
    chk({name, ".cfg3"}, bus.hv_in_config3_o, c2);
    chk({name, ".pend"}, {31'd0, bus.cfg_pending_o}, {31'd0, pend});
  endtask

  initial begin
    // sync tick vt pc il ack -> state mode_vt mode_il irq(raw)
    tbl[0]  = mk(1,0,525,450450,0,0, 1,  0,0,0);
    tbl[1]  = mk(1,1,525,450450,0,0, 1,  0,0,0);  // ref load
    tbl[2]  = mk(1,0,525,450450,0,0, 1,  0,0,0);
    tbl[3]  = mk(1,1,525,450450,0,0, 1,  0,0,0);
    tbl[4]  = mk(1,1,525,450450,0,0, 1,  0,0,0);
    tbl[5]  = mk(1,1,525,450450,0,0, 1,  0,0,0);
    tbl[6]  = mk(1,1,525,450450,0,0, 2,525,0,1);  // 5th tick locks
    tbl[7]  = mk(1,0,525,450450,0,1, 2,525,0,0);
    tbl[8]  = mk(1,1,526,450500,0,0, 2,525,0,0);  // within tolerance
    tbl[9]  = mk(1,1,525,450450,1,0, 1,525,0,1);  // interlace flips
    tbl[10] = mk(1,0,525,450450,1,1, 1,525,0,0);
    tbl[11] = mk(1,1,525,450450,1,0, 1,525,0,0);
    tbl[12] = mk(1,1,525,450450,1,0, 1,525,0,0);
    tbl[13] = mk(1,1,525,450450,1,0, 1,525,0,0);
    tbl[14] = mk(1,1,525,450450,1,1, 2,525,1,1);  // lock + ack same cycle
    tbl[15] = mk(1,0,525,450450,1,1, 2,525,1,0);
    tbl[16] = mk(0,0,525,450450,1,0, 0,525,1,1);  // sync loss
    tbl[17] = mk(0,1,525,450450,1,1, 0,525,1,0);  // tick ignored without sync
    tbl[18] = mk(1,0,525,450450,0,0, 1,525,1,0);
    tbl[19] = mk(1,1,525,450450,0,0, 1,525,1,0);
    tbl[20] = mk(1,1,525,450450,0,0, 1,525,1,0);
    tbl[21] = mk(1,1,525,450450,0,0, 1,525,1,0);
    tbl[22] = mk(1,1,525,450450,0,0, 1,525,1,0);
    tbl[23] = mk(1,1,525,450450,0,0, 2,525,0,1);
    tbl[24] = mk(1,0,525,450450,0,1, 2,525,0,0);
    tbl[25] = mk(1,1,526,450500,0,0, 2,525,0,0);
    tbl[26] = mk(1,1,527,450450,0,0, 1,525,0,1);  // vtotal off by 2
    tbl[27] = mk(1,0,527,450450,0,1, 1,525,0,0);
    tbl[28] = mk(1,1,527,450450,0,0, 1,525,0,0);
    tbl[29] = mk(1,1,527,450450,0,0, 1,525,0,0);
    tbl[30] = mk(1,1,527,450450,0,0, 1,525,0,0);
    tbl[31] = mk(1,1,527,450450,0,0, 2,527,0,1);  // relock 4 ticks later
    tbl[32] = mk(1,0,527,450450,0,1, 2,527,0,0);
    tbl[33] = mk(1,1,527,450514,0,0, 2,527,0,0);  // pcnt diff exactly 64
    tbl[34] = mk(1,1,527,450515,0,0, 1,527,0,1);  // pcnt diff 65
    tbl[35] = mk(1,0,527,450515,0,1, 1,527,0,0);

    drive(0, 0, 0, 0, 0, 0);
    bus.cfg_wr_i = 0; bus.cfg_sel_i = 0; bus.cfg_wdata_i = 0; bus.cfg_commit_i = 0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst.state", {30'd0, bus.mode_state_o}, 32'd0);
    chk("rst.mvt",   {21'd0, bus.mode_vtotal_o}, 32'd0);
    chk("rst.mpc",   {12'd0, bus.mode_pcnt_frame_o}, 32'd0);
    chk("rst.irq",   {31'd0, bus.irq_o}, 32'd0);
    chk_cfg("rst", 0, 0, 0, 0);
    grst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      drive(tbl[i].sync, tbl[i].tick, tbl[i].vt, tbl[i].pc, tbl[i].il, tbl[i].ack);
      step();
      chk($sformatf("v%0d.state", i), {30'd0, bus.mode_state_o}, {30'd0, tbl[i].st});
      chk($sformatf("v%0d.mvt", i),   {21'd0, bus.mode_vtotal_o}, {21'd0, tbl[i].mvt});
      chk($sformatf("v%0d.mil", i),   {31'd0, bus.mode_interlace_o}, {31'd0, tbl[i].mil});
      chk($sformatf("v%0d.irq", i),   {31'd0, bus.irq_o}, {31'd0, tbl[i].irq & IRQ_EN});
    end

    // Relock on ref 527/450515, then frame-aligned commit.
    for (int i = 0; i < 4; i++) begin drive(1, 1, 527, 450515, 0, 0); step(); end
    chk("relock.state", {30'd0, bus.mode_state_o}, 32'd2);
    chk("relock.mpc",   {12'd0, bus.mode_pcnt_frame_o}, 32'd450515);
    drive(1, 0, 527, 450515, 0, 1); step();
    wr(2'd0, 32'h1111_1111);
    wr(2'd1, 32'h2222_2222);
    wr(2'd2, 32'h3333_3333);
    wr(2'd3, 32'hDEAD_BEEF);
    chk_cfg("wr_only", 0, 0, 0, 0);
    bus.cfg_commit_i = 1'b1; step();
    chk_cfg("commit", 0, 0, 0, 1);
    step();
    chk_cfg("wait", 0, 0, 0, 1);
    bus.frame_tick_i = 1'b1; step();
    chk_cfg("apply", 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0);

    // Commit coinciding with a tick waits for the following tick.
    wr(2'd0, 32'h4444_4444);
    bus.cfg_commit_i = 1'b1; bus.frame_tick_i = 1'b1; step();
    chk_cfg("race", 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1);
    bus.frame_tick_i = 1'b1; step();
    chk_cfg("race_apply", 32'h4444_4444, 32'h2222_2222, 32'h3333_3333, 0);
    chk("race.state", {30'd0, bus.mode_state_o}, 32'd2);

    // Asynchronous reset while pending.
    bus.cfg_commit_i = 1'b1; step();
    chk("pre_rst.pend", {31'd0, bus.cfg_pending_o}, 32'd1);
    #2 grst_n = 1'b0;
    #1;
    chk_cfg("async_rst", 0, 0, 0, 0);
    chk("async_rst.state", {30'd0, bus.mode_state_o}, 32'd0);
    chk("async_rst.mvt",   {21'd0, bus.mode_vtotal_o}, 32'd0);
    @(posedge gclk); #1;
    drive(0, 0, 0, 0, 0, 0);
    grst_n = 1'b1;

    // In NOSYNC a commit applies on the next cycle.
    wr(2'd1, 32'h5555_5555);
    bus.cfg_commit_i = 1'b1; step();
    chk_cfg("nosync_apply", 0, 32'h5555_5555, 0, 0);
    chk("nosync.state", {30'd0, bus.mode_state_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tvp7002_mode_ctrl.md
# tvp7002_mode_ctrl

Mode-detect and configuration sequencer for the TVP7002 capture frontend. Runs in the measurement clock domain and watches the frontend's measured line total, frame period, interlace flag and sync activity. It debounces them into a stable/unstable mode state and raises a sticky CPU interrupt on every lock, unlock or sync loss. It also double-buffers the frontend's hv_in_config words so that CPU updates reach the frontend atomically on a frame boundary.

## Interface
- STABLE_FRAMES, 4: consecutive matching frame ticks required to lock (2..15).
- VTOTAL_TOL, 1: allowed absolute difference in vtotal, lines.
- PCNT_TOL, 64: allowed absolute difference in pcnt_frame, CLK_MEAS_i cycles.

- CLK_MEAS_i  in  1  measurement clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- sync_active_i  in  1  frontend sync activity.
- vtotal_i  in  11  measured lines per frame.
- pcnt_frame_i  in  20  measured clocks per frame.
- interlace_i  in  1  frontend interlace flag.
- frame_tick_i  in  1  one-cycle pulse per frame, already synchronous to CLK_MEAS_i.
- cfg_wr_i  in  1  shadow write strobe.
- cfg_sel_i  in  2  shadow select: 0/1/2 = config/config2/config3; 3 = ignored.
- cfg_wdata_i  in  32  shadow write data.
- cfg_commit_i  in  1  request to apply shadows.
- cfg_pending_o  out  1  commit requested but not yet applied.
- hv_in_config_o, hv_in_config2_o, hv_in_config3_o  out  32 each  active configuration to the frontend.
- mode_state_o  out  2  0 = NOSYNC, 1 = ACQUIRE, 2 = LOCKED.
- mode_vtotal_o  out  11  latched locked vtotal.
- mode_pcnt_frame_o  out  20  latched locked pcnt_frame.
- mode_interlace_o  out  1  latched locked interlace.
- irq_o  out  1  sticky mode-event interrupt.
- irq_ack_i  in  1  clears irq_o.

## Operation
- Reset: all outputs are 0, the state is NOSYNC, and the shadows, reference and stable counter are 0.
- A sample "matches" when all of these hold:
  - |vtotal_i − ref_vt| ≤ VTOTAL_TOL
  - |pcnt_frame_i − ref_pc| ≤ PCNT_TOL
  - interlace_i == ref_il
- Differences are computed unsigned, one bit wider than the operand, with no wrap.
- sync_active_i = 0 in any state forces NOSYNC on the next cycle and clears ref_valid and stable_ctr. This takes priority over ticks.
- NOSYNC -> ACQUIRE when sync_active_i = 1, with ref_valid = 0.
- ACQUIRE, on frame_tick_i:
  - If ref_valid = 0: load the ref from the inputs, set ref_valid, and set stable_ctr = 0.
  - Else on a match: stable_ctr increments. When the incremented value equals STABLE_FRAMES, go to LOCKED, latch the mode_* outputs from the current inputs, and set irq.
  - Else on a mismatch: reload the ref from the inputs and set stable_ctr = 0.
- LOCKED, on frame_tick_i:
  - Match: no change.
  - Mismatch: go to ACQUIRE with the ref reloaded from the current inputs, stable_ctr = 0, and irq set.
- Leaving LOCKED because of sync loss also sets irq. mode_* outputs hold their last locked values until the next lock.
- irq: set on any event listed above and cleared by irq_ack_i. If set and ack occur in the same cycle, irq stays 1.
- Shadows: cfg_wr_i writes shadow[cfg_sel_i] and is accepted in every state. Writes made while a commit is pending are included in the eventual apply.
- Commit:
  - cfg_commit_i sets pending (registered).
  - In LOCKED or ACQUIRE, pending applies on the next frame_tick_i: all three outputs load from the shadows in the same cycle and pending clears.
  - In NOSYNC, pending applies on the next cycle without waiting for a tick.
  - A commit arriving in the same cycle as a tick waits for the following tick.

## Timing
- All state, mode_*, irq and hv_in_config* updates are visible on the cycle after the triggering tick or strobe (1-cycle latency).
- Lock occurs on the STABLE_FRAMES-th matching tick after the ref load, i.e. the (STABLE_FRAMES+1)-th tick after entering ACQUIRE when the signal is clean.
- The three config words always change together, never on different cycles.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous) and drops any pending commit.

## Configuration
- MODE_CTRL_IRQ_EN:
  - Defined: irq_o behaves as specified.
  - Undefined: irq_o is a constant 0, irq_ack_i is ignored and no irq register is synthesized. All other behaviour is unchanged.

## Test plan
- Lock: sync_active = 1, then 5 ticks with vtotal = 525, pcnt = 450450, interlace = 0 (STABLE_FRAMES = 4) -> LOCKED the cycle after tick 5; mode_vtotal = 525; irq = 1.
- Tolerance: while locked, a tick with vtotal = 526 and pcnt = 450500 -> stays LOCKED. A tick with vtotal = 527 -> ACQUIRE, irq set; relock 4 ticks later at 527.
- Sync loss: while locked, drop sync_active -> NOSYNC next cycle, irq = 1, mode_vtotal holds 525. Restoring sync gives ACQUIRE.
- Commit: while LOCKED, write sel 0/1/2 with 0x11111111/0x22222222/0x33333333, then commit -> cfg_pending = 1; outputs unchanged until the next tick, then all three update in one cycle and pending = 0. Commit in NOSYNC -> applied 1 cycle later.
- Races:
  - irq set and ack in the same cycle -> irq remains 1.
  - Commit in the same cycle as a tick -> applied on the following tick.
  - Reset asserted while pending -> all outputs 0, pending 0.
